// File: rtl/elevator_motion_controller_if.sv
// rtl/elevator_motion_controller_if.sv - car controller <-> shaft/checker signal bundle; door_hold exists only with DOOR_HOLD_EN
interface elevator_motion_controller_if #(
   parameter int NUM_FLOORS  = 10,
   parameter int FLOOR_WIDTH = 4
);
   logic [NUM_FLOORS-1:0]  call_req;
   logic                   has_request_above;
   logic                   has_request_below;
   logic [FLOOR_WIDTH-1:0] current_floor;
   logic [NUM_FLOORS-1:0]  floor_requests;
   logic                   direction_up;
   logic                   moving;
   logic                   door_open;
   logic                   arrived;
`ifdef DOOR_HOLD_EN
   logic                   door_hold;
`endif

   modport master (
`ifdef DOOR_HOLD_EN
      input  door_hold,
`endif
      input  call_req, has_request_above, has_request_below,
      output current_floor, floor_requests, direction_up, moving, door_open, arrived
   );

   modport slave (
`ifdef DOOR_HOLD_EN
      output door_hold,
`endif
      output call_req, has_request_above, has_request_below,
      input  current_floor, floor_requests, direction_up, moving, door_open, arrived
   );
endinterface

// File: rtl/elevator_motion_controller.sv
// rtl/elevator_motion_controller.sv - SCAN elevator car controller with travel/door timers
// Optional: DOOR_HOLD_EN adds door_hold, which freezes the door countdown while high.
module elevator_motion_controller #(
   parameter int NUM_FLOORS    = 10,
   parameter int FLOOR_WIDTH   = 4,
   parameter int TRAVEL_CYCLES = 8,
   parameter int DOOR_CYCLES   = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   elevator_motion_controller_if.master bus
);
   localparam int TCW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
   localparam int DCW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
   localparam logic [TCW-1:0]         TRAVEL_LOAD = TCW'(TRAVEL_CYCLES - 1);
   localparam logic [DCW-1:0]         DOOR_LOAD   = DCW'(DOOR_CYCLES - 1);
   localparam logic [FLOOR_WIDTH-1:0] TOP_FLOOR   = FLOOR_WIDTH'(NUM_FLOORS - 1);

   typedef enum logic [2:0] {IDLE, MOVE_UP, MOVE_DOWN, CHECK, DOOR_OPEN} state_e;

   state_e                 state_q, state_d;
   logic [FLOOR_WIDTH-1:0] floor_q, floor_d;
   logic [NUM_FLOORS-1:0]  req_q, req_d;
   logic                   dir_up_q, dir_up_d;
   logic                   arrived_q, arrived_d;
   logic [TCW-1:0]         travel_q, travel_d;
   logic [DCW-1:0]         door_q, door_d;

   logic [NUM_FLOORS-1:0]  floor_mask;
   logic                   here_req, door_call, can_up, can_down, hold, clr;

   assign floor_mask = NUM_FLOORS'(1) << floor_q;
   assign here_req   = |(req_q & floor_mask);
   assign door_call  = |(bus.call_req & floor_mask);
   // Checker inputs are masked at the shaft ends so a spurious request can never drive the car out of range.
   assign can_up     = bus.has_request_above && (floor_q != TOP_FLOOR);
   assign can_down   = bus.has_request_below && (floor_q != '0);

`ifdef DOOR_HOLD_EN
   assign hold = bus.door_hold;
`else
   assign hold = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      floor_d   = floor_q;
      dir_up_d  = dir_up_q;
      arrived_d = 1'b0;
      travel_d  = travel_q;
      door_d    = door_q;
      case (state_q)
         IDLE: begin
            if (here_req) begin
               state_d = DOOR_OPEN;
               door_d  = DOOR_LOAD;
            end else if (dir_up_q && can_up) begin
               state_d  = MOVE_UP;
               travel_d = TRAVEL_LOAD;
            end else if (!dir_up_q && can_down) begin
               state_d  = MOVE_DOWN;
               travel_d = TRAVEL_LOAD;
            end else if (can_up) begin
               dir_up_d = 1'b1;
               state_d  = MOVE_UP;
               travel_d = TRAVEL_LOAD;
            end else if (can_down) begin
               dir_up_d = 1'b0;
               state_d  = MOVE_DOWN;
               travel_d = TRAVEL_LOAD;
            end
         end
         MOVE_UP, MOVE_DOWN: begin
            if (travel_q == '0) begin
               floor_d   = (state_q == MOVE_UP) ? floor_q + 1'b1 : floor_q - 1'b1;
               arrived_d = 1'b1;
               state_d   = CHECK;
            end else begin
               travel_d = travel_q - 1'b1;
            end
         end
         CHECK: begin
            if (here_req) begin
               state_d = DOOR_OPEN;
               door_d  = DOOR_LOAD;
            end else if (dir_up_q ? can_up : can_down) begin
               state_d  = dir_up_q ? MOVE_UP : MOVE_DOWN;
               travel_d = TRAVEL_LOAD;
            end else begin
               state_d = IDLE;
            end
         end
         DOOR_OPEN: begin
            if (door_call) begin
               door_d = DOOR_LOAD;
            end else if (hold) begin
               door_d = door_q;
            end else if (door_q == '0) begin
               state_d = IDLE;
            end else begin
               door_d = door_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // The served floor is cleared from door entry until the door closes, beating any same-cycle call.
   assign clr   = (state_q == DOOR_OPEN) || (state_d == DOOR_OPEN);
   assign req_d = (req_q | bus.call_req) & ~(clr ? floor_mask : '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         floor_q   <= '0;
         req_q     <= '0;
         dir_up_q  <= 1'b1;
         arrived_q <= 1'b0;
         travel_q  <= '0;
         door_q    <= '0;
      end else begin
         state_q   <= state_d;
         floor_q   <= floor_d;
         req_q     <= req_d;
         dir_up_q  <= dir_up_d;
         arrived_q <= arrived_d;
         travel_q  <= travel_d;
         door_q    <= door_d;
      end
   end

   assign bus.current_floor  = floor_q;
   assign bus.floor_requests = req_q;
   assign bus.direction_up   = dir_up_q;
   assign bus.moving         = (state_q == MOVE_UP) || (state_q == MOVE_DOWN);
   assign bus.door_open      = (state_q == DOOR_OPEN);
   assign bus.arrived        = arrived_q;
endmodule
